// File: rtl/mips_arb_pkg.sv
// Shared types for the dmem round-robin arbiter.
package mips_arb_pkg;

  localparam int NUM_MST = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  typedef logic mst_id_t;

  function automatic arb_state_t gnt_state(input mst_id_t id);
    return id ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break: on a tie the master that was not granted last wins.
module rr_pick2
  import mips_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_id_t    last,
  output mst_id_t    winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port dmem.
// Optional bus locking is compiled in with `define ARB_LOCK_EN.
module dmem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_req,
  input  logic [1:0]    m_we,
  input  logic [1:0]    m_lock,
  input  logic [AW-1:0] m0_a,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m0_wd,
  input  logic [DW-1:0] m1_wd,
  output logic [1:0]    m_gnt,
  output logic [1:0]    m_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  arb_state_t    state_p0, state_nxt;
  mst_id_t       last, last_nxt;
  mst_id_t       pick_id;
  logic          pick_vld;
  mst_id_t       cur;
  logic          gnt_act;
  logic          rd_fire;
  logic          lock_hold;
  logic [1:0]    vld_p1;
  logic [DW-1:0] rdata_p1;

  rr_pick2 u_pick (
    .req    (m_req),
    .last   (last),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  assign cur     = (state_p0 == ARB_GNT1);
  assign gnt_act = (state_p0 != ARB_IDLE);

`ifdef ARB_LOCK_EN
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);
  logic [3:0] lock_cnt, lock_cnt_nxt;

  // A locked owner keeps the bus until it has used up LOCK_MAX re-grants.
  assign lock_hold = gnt_act && m_req[cur] && m_lock[cur] && (lock_cnt != LOCK_LIM);
  assign lock_cnt_nxt = lock_hold ? lock_cnt + 4'd1 : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_cnt <= 4'd0;
    else     lock_cnt <= lock_cnt_nxt;
  end
`else
  logic unused_lock;
  assign unused_lock = ^{m_lock, 4'(LOCK_MAX)};
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_nxt = ARB_IDLE;
    last_nxt  = last;
    if (lock_hold) begin
      state_nxt = state_p0;
    end else if (pick_vld) begin
      state_nxt = gnt_state(pick_id);
      last_nxt  = pick_id;
    end
  end

  // Stage p0: grant cycle, dmem driven from the owning master
  always_comb begin
    m_gnt  = {state_p0 == ARB_GNT1, state_p0 == ARB_GNT0};
    mem_we = 1'b0;
    mem_a  = '0;
    mem_d  = '0;
    if (gnt_act) begin
      mem_we = m_we[cur] & m_req[cur];
      mem_a  = cur ? m1_a  : m0_a;
      mem_d  = cur ? m1_wd : m0_wd;
    end
  end

  assign rd_fire = gnt_act & m_req[cur] & ~m_we[cur];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ARB_IDLE;
      last     <= 1'b1;
      vld_p1   <= 2'b00;
      rdata_p1 <= '0;
    end else begin
      state_p0 <= state_nxt;
      last     <= last_nxt;
      vld_p1   <= rd_fire ? (cur ? 2'b10 : 2'b01) : 2'b00;
      if (rd_fire) rdata_p1 <= mem_q;
    end
  end

  // Stage p1: registered read return
  assign m_rvalid = vld_p1;
  assign rdata    = rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a rule-level arbitration/memory model.
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int LOCK_MAX = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] m_req, m_we, m_lock, m_gnt, m_rvalid;
  logic [AW-1:0] m0_a, m1_a, mem_a;
  logic [DW-1:0] m0_wd, m1_wd, rdata, mem_d, mem_q;
  logic mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m0_a(m0_a), .m1_a(m1_a), .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  // the dmem itself
  logic [DW-1:0] mem [64];
  assign mem_q = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          lk;
    logic          abort;
  } op_t;

  op_t q0[$];
  op_t q1[$];

  int checks = 0;
  int errors = 0;

  // model state
  int owner, owner_now, last_ref, lcnt;
  logic [1:0] exp_rvalid;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] ref_mem [64];
  int run1, maxrun1;

  // master behaviour: 0 directed, 1 random, 2 continuous read, 3 continuous locked read
  int mode [2];
  logic pending [2];
  logic abort_f [2];
  logic req_v [2];
  logic we_v [2];
  logic lk_v [2];
  logic [AW-1:0] a_v [2];
  logic [DW-1:0] d_v [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    m_req  = {req_v[1], req_v[0]};
    m_we   = {we_v[1], we_v[0]};
    m_lock = {lk_v[1], lk_v[0]};
    m0_a = a_v[0]; m1_a = a_v[1];
    m0_wd = d_v[0]; m1_wd = d_v[1];
  endtask

  task automatic set_op(input int x, input op_t op);
    req_v[x] = 1'b1; we_v[x] = op.we; a_v[x] = op.a; d_v[x] = op.d;
    lk_v[x] = op.lk; abort_f[x] = op.abort; pending[x] = 1'b1;
  endtask

  task automatic pick_new(input int x);
    op_t op;
    op.we = $urandom_range(0, 1);
    op.a = AW'($urandom_range(0, 15));
    op.d = $urandom;
    op.lk = $urandom_range(0, 1);
    op.abort = ($urandom_range(0, 9) == 0);
    case (mode[x])
      0: begin
        if (x == 0 && q0.size() > 0) set_op(0, q0.pop_front());
        else if (x == 1 && q1.size() > 0) set_op(1, q1.pop_front());
        else begin req_v[x] = 1'b0; we_v[x] = 1'b0; lk_v[x] = 1'b0; end
      end
      1: begin
        if ($urandom_range(0, 2) != 0) set_op(x, op);
        else begin req_v[x] = 1'b0; a_v[x] = op.a; end
      end
      default: begin
        op.we = 1'b0; op.abort = 1'b0; op.lk = (mode[x] == 3);
        set_op(x, op);
      end
    endcase
  endtask

  task automatic model_reset();
    owner = -1; last_ref = 1; lcnt = 0;
    exp_rvalid = 2'b00; exp_rdata = '0;
    for (int x = 0; x < 2; x++) begin
      pending[x] = 1'b0; abort_f[x] = 1'b0; req_v[x] = 1'b0; we_v[x] = 1'b0;
      lk_v[x] = 1'b0; a_v[x] = '0; d_v[x] = '0;
    end
    drive();
  endtask

  task automatic cycle();
    int nxt;
    logic exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    @(posedge clk); #1;
    owner_now = owner;
    chk("gnt", m_gnt, (owner < 0) ? 2'b00 : 2'(1 << owner));
    chk("rvalid", m_rvalid, exp_rvalid);
    if (exp_rvalid != 2'b00) chk("rdata", rdata, exp_rdata);
    for (int x = 0; x < 2; x++) if (!pending[x]) pick_new(x);
    if (owner >= 0) begin
      if (pending[owner] && abort_f[owner]) req_v[owner] = 1'b0;
      pending[owner] = 1'b0;
    end
    drive();
    #1;
    exp_we = 1'b0; exp_a = '0; exp_d = '0;
    if (owner >= 0) begin
      exp_we = req_v[owner] & we_v[owner];
      exp_a = a_v[owner];
      exp_d = d_v[owner];
    end
    chk("mem_we", mem_we, exp_we);
    chk("mem_a", mem_a, exp_a);
    chk("mem_d", mem_d, exp_d);
    exp_rvalid = 2'b00;
    if (owner >= 0 && req_v[owner]) begin
      if (we_v[owner]) ref_mem[a_v[owner]] = d_v[owner];
      else begin
        exp_rvalid = 2'(1 << owner);
        exp_rdata = ref_mem[a_v[owner]];
      end
    end
    if (owner == 1) begin
      run1++;
      if (run1 > maxrun1) maxrun1 = run1;
    end else run1 = 0;
    if (LOCK_EN && owner >= 0 && req_v[owner] && lk_v[owner] && lcnt < LOCK_MAX) begin
      nxt = owner;
      lcnt++;
    end else begin
      lcnt = 0;
      if (req_v[0] && req_v[1]) nxt = 1 - last_ref;
      else if (req_v[0]) nxt = 0;
      else if (req_v[1]) nxt = 1;
      else nxt = -1;
      if (nxt >= 0) last_ref = nxt;
    end
    owner = nxt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    op_t op;
    int found;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    mode[0] = 0; mode[1] = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_gnt", m_gnt, 2'b00);
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_rdata", rdata, '0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_a", mem_a, '0);
    #2 rst = 1'b0;

    // single M0 write then read of address 5
    op = '{we: 1'b1, a: AW'(5), d: 32'hDEAD_BEEF, lk: 1'b0, abort: 1'b0};
    q0.push_back(op);
    op.we = 1'b0; op.d = '0;
    q0.push_back(op);
    run(8);
    chk("dmem5", mem[5], 32'hDEAD_BEEF);

    // idle gap then a single read
    run(3);
    op = '{we: 1'b0, a: AW'(9), d: '0, lk: 1'b0, abort: 1'b0};
    q0.push_back(op);
    run(6);

    // M1 drops its write request in the grant cycle, then reads the address back
    op = '{we: 1'b1, a: AW'(7), d: 32'h1234_5678, lk: 1'b0, abort: 1'b1};
    q1.push_back(op);
    op.we = 1'b0; op.abort = 1'b0;
    q1.push_back(op);
    run(8);
    chk("dmem7_kept", mem[7], 32'hA5A5_0000 ^ (7 * 32'h0101_0101));

    // both masters stream reads
    mode[0] = 2; mode[1] = 2;
    run(10);

    // M1 locks while M0 keeps requesting
    mode[1] = 3;
    run(2);
    run1 = 0; maxrun1 = 0;
    run(30);
    chk("m1_run", maxrun1, LOCK_EN ? LOCK_MAX + 1 : 1);

    // random traffic
    mode[0] = 1; mode[1] = 1;
    run(2000);

    // reset in the middle of a grant
    mode[0] = 2; mode[1] = 2;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cycle();
      if (owner_now >= 0) found = 1;
    end
    chk("rst_setup", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", m_gnt, 2'b00);
    chk("mid_rst_rvalid", m_rvalid, 2'b00);
    chk("mid_rst_rdata", rdata, '0);
    chk("mid_rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_rvalid2", m_rvalid, 2'b00);
    mode[0] = 0; mode[1] = 0;
    model_reset();
    #2 rst = 1'b0;

    // first tie after reset goes to M0
    op = '{we: 1'b0, a: AW'(3), d: '0, lk: 1'b0, abort: 1'b0};
    q0.push_back(op);
    op.a = AW'(4);
    q1.push_back(op);
    cycle();
    cycle();
    chk("tie_m0", owner_now, 0);
    run(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
